// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with early completion for divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        op_q;
  logic              special_q, neg_q, rneg_q, busy_q, done_q;
  logic [2*XLEN-1:0] acc_q, opa_q;
  logic [XLEN-1:0]   opb_q, result_q;

  logic              is_div, sign_a, sign_b, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   mag_a, mag_b, special_val, quot, rem, fin_val;
  logic [2*XLEN-1:0] mul_acc, prod;
  logic [XLEN:0]     rem_shift, trial;

  assign is_div   = FUNCT3[2];
  assign sign_a   = OPERAND1[XLEN-1] & (is_div ? ~FUNCT3[0] : (FUNCT3[1:0] != 2'b11));
  assign sign_b   = OPERAND2[XLEN-1] & (is_div ? ~FUNCT3[0] : ~FUNCT3[1]);
  assign mag_a    = sign_a ? -OPERAND1 : OPERAND1;
  assign mag_b    = sign_b ? -OPERAND2 : OPERAND2;
  assign div_zero = is_div & (OPERAND2 == '0);
  assign div_ovf  = is_div & ~FUNCT3[0] & (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) & (&OPERAND2);
  assign special  = div_zero | div_ovf;
  // FLUSH in FIN takes priority over a back-to-back START.
  assign accept   = START & ~((state_q == StFin) & FLUSH);

  always_comb begin
    special_val = '0;
    if (div_zero) special_val = FUNCT3[1] ? OPERAND1 : '1;
    else          special_val = FUNCT3[1] ? '0 : OPERAND1;
  end

  // Multiply: acc += multiplicand when the multiplier LSB is set.
  // Divide: acc holds the partial remainder, opb shifts dividend out and quotient in.
  assign mul_acc   = opb_q[0] ? acc_q + opa_q : acc_q;
  assign rem_shift = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, opa_q[XLEN-1:0]};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -opb_q : opb_q;
  assign rem  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

  always_comb begin
    fin_val = '0;
    if (special_q)    fin_val = acc_q[XLEN-1:0];
    else if (!op_q[2]) fin_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else              fin_val = op_q[1] ? rem : quot;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      special_q <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StFin: begin
          if (accept) begin
            state_q   <= StCalc;
            busy_q    <= 1'b1;
            op_q      <= FUNCT3;
            special_q <= special;
            neg_q     <= sign_a ^ sign_b;
            rneg_q    <= sign_a;
            // Special cases skip straight to the final CALC cycle.
            cnt_q     <= special ? CntW'(XLEN) : '0;
            acc_q     <= special ? {{XLEN{1'b0}}, special_val} : '0;
            opa_q     <= {{XLEN{1'b0}}, is_div ? mag_b : mag_a};
            opb_q     <= is_div ? mag_a : mag_b;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StCalc: begin
          if (FLUSH) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntW'(XLEN)) begin
            result_q <= fin_val;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StFin;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (!op_q[2]) begin
              acc_q <= mul_acc;
              opa_q <= opa_q << 1;
              opb_q <= opb_q >> 1;
            end else if (trial[XLEN]) begin
              acc_q <= {{XLEN{1'b0}}, rem_shift[XLEN-1:0]};
              opb_q <= {opb_q[XLEN-2:0], 1'b0};
            end else begin
              acc_q <= {{XLEN{1'b0}}, trial[XLEN-1:0]};
              opb_q <= {opb_q[XLEN-2:0], 1'b1};
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue, popped on DONE.
module tb_muldiv_sequencer;

  logic        CLK, RESET, START, FLUSH, BUSY, DONE;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1, OPERAND2, RESULT;

  logic [31:0] sb_q[$];
  logic [31:0] last_result;
  int          tests, fails;

  muldiv_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3), .OPERAND1(OPERAND1),
    .OPERAND2(OPERAND2), .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, b);
    @(negedge CLK);
    START = 1'b1; FUNCT3 = f3; OPERAND1 = a; OPERAND2 = b;
    @(posedge CLK);
    #1;
    START = 1'b0; FUNCT3 = 3'($urandom); OPERAND1 = $urandom; OPERAND2 = $urandom;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, b);
    sb_q.push_back(ref_model(f3, a, b));
    drive_start(f3, a, b);
  endtask

  // Issue one op and check result, latency (edges after accept) and BUSY length.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, b,
                        input int exp_edges);
    int n, busy_n;
    logic [31:0] exp;
    issue(f3, a, b);
    n = 0; busy_n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (!DONE) busy_n += int'(BUSY);
    end while (!DONE && n < 80);
    tests++;
    if (!DONE) begin
      fails++;
      $display("FAIL %s timeout: DONE got 0 expected 1 within 80 cycles", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      exp = sb_q.pop_front();
      tests++;
      if (RESULT !== exp) begin
        fails++; $display("FAIL %s result: got %h expected %h", name, RESULT, exp);
      end
      tests++;
      if (n - 1 != exp_edges) begin
        fails++; $display("FAIL %s latency: got %0d expected %0d", name, n - 1, exp_edges);
      end
      tests++;
      if (busy_n != exp_edges) begin
        fails++; $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, exp_edges);
      end
      tests++;
      if (BUSY !== 1'b0) begin
        fails++; $display("FAIL %s busy in done cycle: got %b expected 0", name, BUSY);
      end
      last_result = exp;
      @(negedge CLK);
      tests++;
      if (DONE !== 1'b0) begin
        fails++; $display("FAIL %s done pulse width: got %b expected 0", name, DONE);
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    bit seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL %s spurious done: got 1 expected 0", name);
    end
    tests++;
    if (RESULT !== last_result) begin
      fails++; $display("FAIL %s result held: got %h expected %h", name, RESULT, last_result);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; START = 1'b0; FLUSH = 1'b0; FUNCT3 = 3'd0; OPERAND1 = '0; OPERAND2 = '0;
    repeat (2) @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", BUSY); end
    tests++;
    if (DONE !== 1'b0) begin fails++; $display("FAIL reset done: got %b expected 0", DONE); end
    tests++;
    if (RESULT !== 32'h0) begin
      fails++; $display("FAIL reset result: got %h expected 00000000", RESULT);
    end
    last_result = 32'h0;
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mul();
    run_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 33);
    run_op("mulh", 3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 33);
    run_op("mulhu", 3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 33);
    run_op("mulhsu", 3'd2, 32'h8000_0001, 32'h1234_5678, 33);
  endtask

  task automatic test_div();
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 33);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 33);
    run_op("divu", 3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 33);
    run_op("remu", 3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 33);
  endtask

  task automatic test_special();
    run_op("divu_by_zero", 3'd5, 32'd5, 32'd0, 1);
    run_op("rem_by_zero", 3'd6, 32'd5, 32'd0, 1);
    run_op("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp;
    issue(3'd0, 32'h0001_2345, 32'h0000_6789);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 10) begin
        START = 1'b1; FUNCT3 = 3'd5; OPERAND1 = $urandom; OPERAND2 = $urandom;
      end else begin
        START = 1'b0;
      end
    end while (!DONE && n < 80);
    tests++;
    if (!DONE || n != 34) begin
      fails++; $display("FAIL b2b first latency: got %0d expected 33", n - 1);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
    tests++;
    if (RESULT !== exp) begin
      fails++; $display("FAIL b2b first result: got %h expected %h", RESULT, exp);
    end
    // Second op requested in the FIN cycle.
    START = 1'b1; FUNCT3 = 3'd6; OPERAND1 = 32'hFFFF_FF00; OPERAND2 = 32'h0000_0007;
    sb_q.push_back(ref_model(3'd6, 32'hFFFF_FF00, 32'h0000_0007));
    @(posedge CLK);
    #1 START = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < 80);
    tests++;
    if (!DONE || n != 34) begin
      fails++; $display("FAIL b2b second latency: got %0d expected 33", n - 1);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
    tests++;
    if (RESULT !== exp) begin
      fails++; $display("FAIL b2b second result: got %h expected %h", RESULT, exp);
    end
    last_result = exp;
    check_quiet("b2b after", 40);
  endtask

  task automatic test_flush();
    int n;
    logic [31:0] exp;
    drive_start(3'd0, 32'd3, 32'd5);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (n < 15);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1 FLUSH = 1'b0;
    @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL flush busy: got %b expected 0", BUSY); end
    check_quiet("flush calc", 40);

    issue(3'd5, 32'd100, 32'd7);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < 80);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
    tests++;
    if (!DONE || RESULT !== exp) begin
      fails++; $display("FAIL flush pre-op result: got %h expected %h", RESULT, exp);
    end
    last_result = exp;
    FLUSH = 1'b1; START = 1'b1; FUNCT3 = 3'd0; OPERAND1 = 32'd9; OPERAND2 = 32'd9;
    @(posedge CLK);
    #1 FLUSH = 1'b0; START = 1'b0;
    @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin
      fails++; $display("FAIL flush+start busy: got %b expected 0", BUSY);
    end
    check_quiet("flush+start", 40);
  endtask

  task automatic test_reset_mid();
    int n;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (n < 10);
    #1 RESET = 1'b0;
    #1;
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL async reset busy: got %b expected 0", BUSY); end
    tests++;
    if (DONE !== 1'b0) begin fails++; $display("FAIL async reset done: got %b expected 0", DONE); end
    tests++;
    if (RESULT !== 32'h0) begin
      fails++; $display("FAIL async reset result: got %h expected 00000000", RESULT);
    end
    sb_q.delete();
    last_result = 32'h0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    run_op("mulhsu after reset", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = (i == 3) ? 32'h0 : $urandom;
      run_op("random", f3, a, b, is_special(f3, a, b) ? 1 : 33);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
